// File: rtl/sum_display_driver.sv
// rtl/sum_display_driver.sv - adder result to 2-digit multiplexed 7-segment display
//
// Captures a 5-bit adder result {cout, s[3:0]} on a valid strobe and converts
// it to two BCD digits with a sequential double-dabble FSM. It then drives a
// 2-digit multiplexed 7-segment display and blanks a leading zero in the tens
// digit.
//
// Ports:
//   clk       in   system clock
//   rst       in   asynchronous, active-high reset
//   sum_in    in   [4:0] adder result, bit4 = cout, bits3:0 = s
//   sum_valid in   single-cycle strobe; ignored while busy
//   busy      out  high while a conversion is in progress
//   seg       out  [6:0] segment lines, bit0 = a .. bit6 = g
//   dig       out  [1:0] digit enables, bit0 = ones, bit1 = tens

module sum_display_driver #(
  parameter int unsigned SCAN_DIV       = 13500,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] sum_in,
  input  logic       sum_valid,
  output logic       busy,
  output logic [6:0] seg,
  output logic [1:0] dig
);

  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);

  localparam logic [6:0] SEG_POL = {7{SEG_ACTIVE_LOW}};
  localparam logic [1:0] DIG_POL = {2{DIG_ACTIVE_LOW}};

  // Reset shows a '0' on the ones digit.
  localparam logic [6:0] SEG_RST = 7'b0111111 ^ SEG_POL;
  localparam logic [1:0] DIG_RST = 2'b01 ^ DIG_POL;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    LOAD = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [4:0]        shift_q, shift_d;
  logic [7:0]        bcd_q, bcd_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [3:0]        disp_tens_q, disp_tens_d;
  logic [3:0]        disp_ones_q, disp_ones_d;
  logic [SCAN_W-1:0] scan_q, scan_d;
  logic              sel_q, sel_d;
  logic [6:0]        seg_q, seg_d;
  logic [1:0]        dig_q, dig_d;

  logic [7:0]        adj;

  function automatic logic [6:0] encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0111111;
      4'd1:    s = 7'b0000110;
      4'd2:    s = 7'b1011011;
      4'd3:    s = 7'b1001111;
      4'd4:    s = 7'b1100110;
      4'd5:    s = 7'b1101101;
      4'd6:    s = 7'b1111101;
      4'd7:    s = 7'b0000111;
      4'd8:    s = 7'b1111111;
      4'd9:    s = 7'b1101111;
      default: s = 7'b0000000;
    endcase
    return s;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      bcd_q       <= '0;
      cnt_q       <= '0;
      disp_tens_q <= '0;
      disp_ones_q <= '0;
      scan_q      <= '0;
      sel_q       <= 1'b0;
      seg_q       <= SEG_RST;
      dig_q       <= DIG_RST;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bcd_q       <= bcd_d;
      cnt_q       <= cnt_d;
      disp_tens_q <= disp_tens_d;
      disp_ones_q <= disp_ones_d;
      scan_q      <= scan_d;
      sel_q       <= sel_d;
      seg_q       <= seg_d;
      dig_q       <= dig_d;
    end
  end

  // Conversion FSM
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bcd_d       = bcd_q;
    cnt_d       = cnt_q;
    disp_tens_d = disp_tens_q;
    disp_ones_d = disp_ones_q;

    // Add-3 correction so each nibble stays decimal after the next shift.
    adj[3:0] = (bcd_q[3:0] >= 4'd5) ? bcd_q[3:0] + 4'd3 : bcd_q[3:0];
    adj[7:4] = (bcd_q[7:4] >= 4'd5) ? bcd_q[7:4] + 4'd3 : bcd_q[7:4];

    case (state_q)
      IDLE: begin
        if (sum_valid) begin
          shift_d = sum_in;
          bcd_d   = '0;
          cnt_d   = '0;
          state_d = CONV;
        end
      end
      CONV: begin
        {bcd_d, shift_d} = {adj, shift_q} << 1;
        cnt_d = cnt_q + 3'd1;
        // cnt_q == 4 means this edge performs the fifth and final shift.
        if (cnt_q == 3'd4) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        disp_tens_d = bcd_q[7:4];
        disp_ones_d = bcd_q[3:0];
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Digit scan and registered display outputs
  always_comb begin
    scan_d = scan_q + SCAN_W'(1);
    sel_d  = sel_q;
    if (scan_q == SCAN_LAST) begin
      scan_d = '0;
      sel_d  = ~sel_q;
    end

    seg_d = encode(disp_ones_q) ^ SEG_POL;
    dig_d = 2'b01 ^ DIG_POL;
    if (sel_q) begin
      if (disp_tens_q != 4'd0) begin
        seg_d = encode(disp_tens_q) ^ SEG_POL;
        dig_d = 2'b10 ^ DIG_POL;
      end else begin
        // Leading-zero blank: nothing lit, no digit selected.
        seg_d = SEG_POL;
        dig_d = DIG_POL;
      end
    end
  end

  assign busy = (state_q != IDLE);
  assign seg  = seg_q;
  assign dig  = dig_q;

endmodule

// File: tb/tb_sum_display_driver.sv
// tb/tb_sum_display_driver.sv - directed-vector bench for sum_display_driver
`timescale 1ns/1ps

module tb_sum_display_driver;

  localparam int unsigned SCAN_DIV = 4;

  localparam logic [6:0] SEG_D0    = 7'b1000000;
  localparam logic [6:0] SEG_D1    = 7'b1111001;
  localparam logic [6:0] SEG_D2    = 7'b0100100;
  localparam logic [6:0] SEG_D3    = 7'b0110000;
  localparam logic [6:0] SEG_D7    = 7'b1111000;
  localparam logic [6:0] SEG_D9    = 7'b0010000;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [1:0] DIG_ONES  = 2'b10;
  localparam logic [1:0] DIG_TENS  = 2'b01;
  localparam logic [1:0] DIG_NONE  = 2'b11;

  logic       clk;
  logic       rst;
  logic [4:0] sum_in;
  logic       sum_valid;
  logic       busy;
  logic [6:0] seg;
  logic [1:0] dig;

  int n_vec = 0;
  int n_err = 0;
  int unsigned cyc;

  sum_display_driver #(
    .SCAN_DIV(SCAN_DIV),
    .SEG_ACTIVE_LOW(1'b1),
    .DIG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sum_in(sum_in),
    .sum_valid(sum_valid),
    .busy(busy),
    .seg(seg),
    .dig(dig)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edges since reset release; drives the expected scan phase.
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // Output after edge k reflects sel after edge k-1, which toggles every SCAN_DIV edges.
  function automatic int phase_of(input int unsigned c);
    if (c == 0) return 0;
    return int'(((c - 1) / SCAN_DIV) % 2);
  endfunction

  task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  task automatic wait_phase(input int p);
    int n = 0;
    while (phase_of(cyc) != p && n < 4 * SCAN_DIV + 4) begin
      @(negedge clk);
      n++;
    end
    if (phase_of(cyc) != p) chk_vec("phase_timeout", 32'd0, 32'd1);
  endtask

  task automatic check_phase(input string tag, input int p,
                             input logic [6:0] seg_e, input logic [1:0] dig_e);
    wait_phase(p);
    chk_vec({tag, "_seg"}, 32'(seg), 32'(seg_e));
    chk_vec({tag, "_dig"}, 32'(dig), 32'(dig_e));
  endtask

  task automatic strobe(input logic [4:0] v);
    sum_in    = v;
    sum_valid = 1'b1;
    @(negedge clk);
    sum_valid = 1'b0;
  endtask

  // Waits for busy to fall plus one cycle so the output register has caught up with LOAD.
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (busy) chk_vec("busy_timeout", 32'd1, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    int bc;
    rst       = 1'b1;
    sum_in    = '0;
    sum_valid = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk_vec("rst_busy", 32'(busy), 32'd0);
    chk_vec("rst_seg", 32'(seg), 32'(SEG_D0));
    chk_vec("rst_dig", 32'(dig), 32'(DIG_ONES));
    rst = 1'b0;
    check_phase("rst_ones", 0, SEG_D0, DIG_ONES);
    check_phase("rst_tens", 1, SEG_BLANK, DIG_NONE);

    // 23: busy for exactly six cycles
    @(negedge clk);
    chk_vec("pre_busy", 32'(busy), 32'd0);
    strobe(5'b10111);
    bc = 0;
    while (busy && bc < 20) begin
      bc++;
      @(negedge clk);
    end
    chk_vec("busy_len", 32'(bc), 32'd6);
    @(negedge clk);
    check_phase("s23_ones", 0, SEG_D3, DIG_ONES);
    check_phase("s23_tens", 1, SEG_D2, DIG_TENS);

    // 7: tens blanked
    strobe(5'd7);
    wait_idle();
    check_phase("s7_ones", 0, SEG_D7, DIG_ONES);
    check_phase("s7_tens", 1, SEG_BLANK, DIG_NONE);

    // 23 then 9 while busy (dropped), then 9 again once idle
    strobe(5'd23);
    @(negedge clk);
    strobe(5'd9);
    wait_idle();
    check_phase("drop_ones", 0, SEG_D3, DIG_ONES);
    check_phase("drop_tens", 1, SEG_D2, DIG_TENS);
    strobe(5'd9);
    wait_idle();
    check_phase("s9_ones", 0, SEG_D9, DIG_ONES);
    check_phase("s9_tens", 1, SEG_BLANK, DIG_NONE);

    // 31 (max) then 0
    strobe(5'd31);
    wait_idle();
    check_phase("s31_ones", 0, SEG_D1, DIG_ONES);
    check_phase("s31_tens", 1, SEG_D3, DIG_TENS);
    strobe(5'd0);
    wait_idle();
    check_phase("s0_ones", 0, SEG_D0, DIG_ONES);
    check_phase("s0_tens", 1, SEG_BLANK, DIG_NONE);

    // Reset at edge N+3 aborts the conversion of 23
    strobe(5'd23);
    @(negedge clk);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk_vec("abort_busy", 32'(busy), 32'd0);
    chk_vec("abort_seg", 32'(seg), 32'(SEG_D0));
    chk_vec("abort_dig", 32'(dig), 32'(DIG_ONES));
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 24; i++) begin
      if (phase_of(cyc) == 0) begin
        chk_vec("abort_ones_seg", 32'(seg), 32'(SEG_D0));
        chk_vec("abort_ones_dig", 32'(dig), 32'(DIG_ONES));
      end else begin
        chk_vec("abort_tens_seg", 32'(seg), 32'(SEG_BLANK));
        chk_vec("abort_tens_dig", 32'(dig), 32'(DIG_NONE));
      end
      chk_vec("abort_idle", 32'(busy), 32'd0);
      @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
